// File: rtl/dict_fill_compressor.sv
// Fill-path instruction compressor: splits each 32-bit word into 7/15/10-bit fields,
// looks each up in a programmable dictionary, and emits a 16-bit code when all three hit.
module dict_fill_compressor #(
  parameter int unsigned FIELD1_KEY_WIDTH = 3,
  parameter int unsigned FIELD2_KEY_WIDTH = 8,
  parameter int unsigned FIELD3_KEY_WIDTH = 5,
  parameter int unsigned FIELD1_VAL_SIZE  = 7,
  parameter int unsigned FIELD2_VAL_SIZE  = 15,
  parameter int unsigned FIELD3_VAL_SIZE  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic        dict_we,
  input  logic [1:0]  dict_sel,
  input  logic [7:0]  dict_idx,
  input  logic [14:0] dict_val,
  input  logic        dict_clear,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic        out_hit,
  output logic [15:0] out_code,
  output logic [31:0] out_raw,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned N1     = 1 << FIELD1_KEY_WIDTH;
  localparam int unsigned N2     = 1 << FIELD2_KEY_WIDTH;
  localparam int unsigned N3     = 1 << FIELD3_KEY_WIDTH;
  localparam int unsigned F2_LSB = FIELD3_VAL_SIZE;
  localparam int unsigned CNT_W  = 32;

  // Dictionary storage: values carry no reset, only the valid bits do.
  logic [FIELD1_VAL_SIZE-1:0] r_d1_val [N1];
  logic [FIELD2_VAL_SIZE-1:0] r_d2_val [N2];
  logic [FIELD3_VAL_SIZE-1:0] r_d3_val [N3];
  logic [N1-1:0]              r_d1_vld;
  logic [N2-1:0]              r_d2_vld;
  logic [N3-1:0]              r_d3_vld;

  logic                       r_rdy_en;
  logic                       r_a_valid;
  logic [31:0]                r_a_addr;
  logic [31:0]                r_a_data;

  logic                       r_out_valid;
  logic [31:0]                r_out_addr;
  logic                       r_out_hit;
  logic [15:0]                r_out_code;
  logic [31:0]                r_out_raw;
  logic [CNT_W-1:0]           r_hit_count;
  logic [CNT_W-1:0]           r_miss_count;

  logic                       w_adv_a;
  logic                       w_adv_b;
  logic                       w_accept;
  logic                       w_handoff;
  logic [FIELD1_VAL_SIZE-1:0] w_f1;
  logic [FIELD2_VAL_SIZE-1:0] w_f2;
  logic [FIELD3_VAL_SIZE-1:0] w_f3;
  logic                       w_m1;
  logic                       w_m2;
  logic                       w_m3;
  logic [FIELD1_KEY_WIDTH-1:0] w_k1;
  logic [FIELD2_KEY_WIDTH-1:0] w_k2;
  logic [FIELD3_KEY_WIDTH-1:0] w_k3;
  logic                       w_hit;
  logic                       w_unused_bits;

  assign w_adv_b   = !r_out_valid || out_ready;
  assign w_adv_a   = !r_a_valid || w_adv_b;
  assign in_ready  = r_rdy_en && w_adv_a;
  assign w_accept  = in_valid && in_ready;
  assign w_handoff = r_out_valid && out_ready;

  assign w_f1 = r_a_data[31 -: FIELD1_VAL_SIZE];
  assign w_f2 = r_a_data[F2_LSB +: FIELD2_VAL_SIZE];
  assign w_f3 = r_a_data[0 +: FIELD3_VAL_SIZE];

  // Upper index/value bits are don't-care for the narrower dictionaries.
  assign w_unused_bits = &{1'b0, dict_idx, dict_val};

  always_ff @(posedge clk) begin
    if (dict_we) begin
      case (dict_sel)
        2'd0: r_d1_val[dict_idx[FIELD1_KEY_WIDTH-1:0]] <= dict_val[FIELD1_VAL_SIZE-1:0];
        2'd1: r_d2_val[dict_idx[FIELD2_KEY_WIDTH-1:0]] <= dict_val[FIELD2_VAL_SIZE-1:0];
        2'd2: r_d3_val[dict_idx[FIELD3_KEY_WIDTH-1:0]] <= dict_val[FIELD3_VAL_SIZE-1:0];
        default: ;
      endcase
    end
  end

  // Clear takes priority over a simultaneous write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d1_vld <= '0;
      r_d2_vld <= '0;
      r_d3_vld <= '0;
    end else if (dict_clear) begin
      r_d1_vld <= '0;
      r_d2_vld <= '0;
      r_d3_vld <= '0;
    end else if (dict_we) begin
      case (dict_sel)
        2'd0: r_d1_vld[dict_idx[FIELD1_KEY_WIDTH-1:0]] <= 1'b1;
        2'd1: r_d2_vld[dict_idx[FIELD2_KEY_WIDTH-1:0]] <= 1'b1;
        2'd2: r_d3_vld[dict_idx[FIELD3_KEY_WIDTH-1:0]] <= 1'b1;
        default: ;
      endcase
    end
  end

  // Parallel lookup; descending scan leaves the lowest matching index.
  always_comb begin
    w_m1 = 1'b0;
    w_k1 = '0;
    for (int i = int'(N1) - 1; i >= 0; i--) begin
      if (r_d1_vld[i] && (r_d1_val[i] == w_f1)) begin
        w_m1 = 1'b1;
        w_k1 = FIELD1_KEY_WIDTH'(i);
      end
    end
  end

  always_comb begin
    w_m2 = 1'b0;
    w_k2 = '0;
    for (int i = int'(N2) - 1; i >= 0; i--) begin
      if (r_d2_vld[i] && (r_d2_val[i] == w_f2)) begin
        w_m2 = 1'b1;
        w_k2 = FIELD2_KEY_WIDTH'(i);
      end
    end
  end

  always_comb begin
    w_m3 = 1'b0;
    w_k3 = '0;
    for (int i = int'(N3) - 1; i >= 0; i--) begin
      if (r_d3_vld[i] && (r_d3_val[i] == w_f3)) begin
        w_m3 = 1'b1;
        w_k3 = FIELD3_KEY_WIDTH'(i);
      end
    end
  end

  assign w_hit = w_m1 && w_m2 && w_m3;

  // Stage A capture, plus a one-cycle hold-off on in_ready after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdy_en  <= 1'b0;
      r_a_valid <= 1'b0;
      r_a_addr  <= '0;
      r_a_data  <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_adv_a) begin
        r_a_valid <= w_accept;
      end
      if (w_accept) begin
        r_a_addr <= in_addr;
        r_a_data <= in_data;
      end
    end
  end

  // Stage B result register; holds while the downstream stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_hit   <= 1'b0;
      r_out_code  <= '0;
      r_out_raw   <= '0;
    end else if (w_adv_b) begin
      r_out_valid <= r_a_valid;
      if (r_a_valid) begin
        r_out_addr <= r_a_addr;
        r_out_raw  <= r_a_data;
        r_out_hit  <= w_hit;
        r_out_code <= w_hit ? {w_k1, w_k2, w_k3} : 16'h0000;
      end
    end
  end

  // Saturating handoff statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (w_handoff) begin
      if (r_out_hit) begin
        if (r_hit_count != {CNT_W{1'b1}}) r_hit_count <= r_hit_count + CNT_W'(1);
      end else begin
        if (r_miss_count != {CNT_W{1'b1}}) r_miss_count <= r_miss_count + CNT_W'(1);
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_addr   = r_out_addr;
  assign out_hit    = r_out_hit;
  assign out_code   = r_out_code;
  assign out_raw    = r_out_raw;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

endmodule

// File: tb/tb_dict_fill_compressor.sv
// Directed self-checking bench for dict_fill_compressor.
module tb_dict_fill_compressor;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic        dict_we;
  logic [1:0]  dict_sel;
  logic [7:0]  dict_idx;
  logic [14:0] dict_val;
  logic        dict_clear;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic        out_hit;
  logic [15:0] out_code;
  logic [31:0] out_raw;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int n_checks = 0;
  int n_fail   = 0;

  dict_fill_compressor dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .dict_we(dict_we), .dict_sel(dict_sel), .dict_idx(dict_idx), .dict_val(dict_val),
    .dict_clear(dict_clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_hit(out_hit),
    .out_code(out_code), .out_raw(out_raw), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dict_write(input logic [1:0] sel, input logic [7:0] idx, input logic [14:0] val);
    dict_we = 1'b1; dict_sel = sel; dict_idx = idx; dict_val = val;
    tick();
    dict_we = 1'b0;
  endtask

  task automatic clear_dicts();
    dict_clear = 1'b1;
    tick();
    dict_clear = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] addr, input logic [31:0] data);
    in_valid = 1'b1; in_addr = addr; in_data = data;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    n_checks++; if (hit_count !== 32'd0) begin n_fail++; $display("FAIL reset_hit_count got %0d exp 0", hit_count); end
    n_checks++; if (miss_count !== 32'd0) begin n_fail++; $display("FAIL reset_miss_count got %0d exp 0", miss_count); end
    n_checks++; if (out_raw !== 32'd0) begin n_fail++; $display("FAIL reset_out_raw got %h exp 0", out_raw); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %0b exp 0", in_ready); end
    @(negedge clk);
    reset = 1'b0;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %0b exp 1", in_ready); end
  endtask

  task automatic test_hit();
    dict_write(2'd0, 8'd2, 15'h0000);
    dict_write(2'd1, 8'd5, 15'h0008);
    dict_write(2'd2, 8'd3, 15'h0202);
    out_ready = 1'b1;
    send_word(32'h0000_0100, 32'h0000_2202);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hit_latency_early got %0b exp 0", out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hit_out_valid got %0b exp 1", out_valid); end
    n_checks++; if (out_hit !== 1'b1) begin n_fail++; $display("FAIL hit_out_hit got %0b exp 1", out_hit); end
    n_checks++; if (out_code !== 16'h40A3) begin n_fail++; $display("FAIL hit_out_code got %h exp 40a3", out_code); end
    n_checks++; if (out_raw !== 32'h0000_2202) begin n_fail++; $display("FAIL hit_out_raw got %h exp 00002202", out_raw); end
    n_checks++; if (out_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL hit_out_addr got %h exp 00000100", out_addr); end
    tick();
    n_checks++; if (hit_count !== 32'd1) begin n_fail++; $display("FAIL hit_count got %0d exp 1", hit_count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hit_drain_valid got %0b exp 0", out_valid); end
  endtask

  task automatic test_miss();
    clear_dicts();
    send_word(32'h0000_0200, 32'hDEAD_BEEF);
    tick();
    n_checks++; if (out_hit !== 1'b0) begin n_fail++; $display("FAIL miss_out_hit got %0b exp 0", out_hit); end
    n_checks++; if (out_code !== 16'h0000) begin n_fail++; $display("FAIL miss_out_code got %h exp 0000", out_code); end
    n_checks++; if (out_raw !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL miss_out_raw got %h exp deadbeef", out_raw); end
    tick();
    n_checks++; if (miss_count !== 32'd1) begin n_fail++; $display("FAIL miss_count got %0d exp 1", miss_count); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1; in_addr = 32'h10; in_data = 32'h1111_1111;
    tick();
    in_addr = 32'h14; in_data = 32'h2222_2222;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_w1 got %0b exp 1", in_ready); end
    tick();
    in_addr = 32'h18; in_data = 32'h3333_3333;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready got %0b exp 0", in_ready); end
    n_checks++; if (out_raw !== 32'h1111_1111) begin n_fail++; $display("FAIL b2b_stall_raw0 got %h exp 11111111", out_raw); end
    tick();
    tick();
    n_checks++; if (out_raw !== 32'h1111_1111 || out_addr !== 32'h10 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_hold raw %h addr %h valid %0b exp 11111111 10 1", out_raw, out_addr, out_valid);
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_release_ready got %0b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_raw !== 32'h2222_2222) begin n_fail++; $display("FAIL b2b_drain1 got %h exp 22222222", out_raw); end
    tick();
    n_checks++; if (out_raw !== 32'h3333_3333 || out_addr !== 32'h18) begin
      n_fail++; $display("FAIL b2b_drain2 raw %h addr %h exp 33333333 18", out_raw, out_addr);
    end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got %0b exp 0", out_valid); end
    n_checks++; if (miss_count !== 32'd4) begin n_fail++; $display("FAIL b2b_miss_count got %0d exp 4", miss_count); end
  endtask

  task automatic test_priority_clear();
    dict_write(2'd0, 8'd2, 15'h0000);
    dict_write(2'd1, 8'd9, 15'h0008);
    dict_write(2'd1, 8'd4, 15'h0008);
    dict_write(2'd2, 8'd3, 15'h0202);
    dict_write(2'd3, 8'd0, 15'h0008);
    send_word(32'h0000_0300, 32'h0000_2202);
    tick();
    n_checks++; if (out_hit !== 1'b1 || out_code !== 16'h4083) begin
      n_fail++; $display("FAIL prio_code hit %0b code %h exp 1 4083", out_hit, out_code);
    end
    dict_clear = 1'b1;
    dict_write(2'd1, 8'd5, 15'h0008);
    dict_clear = 1'b0;
    send_word(32'h0000_0304, 32'h0000_2202);
    tick();
    n_checks++; if (out_hit !== 1'b0 || out_code !== 16'h0000) begin
      n_fail++; $display("FAIL clear_wins hit %0b code %h exp 0 0000", out_hit, out_code);
    end
    tick();
  endtask

  task automatic test_same_edge_write();
    dict_write(2'd0, 8'd2, 15'h0000);
    dict_write(2'd2, 8'd3, 15'h0202);
    send_word(32'h0000_0400, 32'h0000_2202);
    in_valid = 1'b1; in_addr = 32'h0000_0404; in_data = 32'h0000_2202;
    dict_write(2'd1, 8'd5, 15'h0008);
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_hit !== 1'b0) begin
      n_fail++; $display("FAIL same_edge_miss valid %0b hit %0b exp 1 0", out_valid, out_hit);
    end
    tick();
    n_checks++; if (out_hit !== 1'b1 || out_code !== 16'h40A3 || out_addr !== 32'h0000_0404) begin
      n_fail++; $display("FAIL next_word_hit hit %0b code %h addr %h exp 1 40a3 404", out_hit, out_code, out_addr);
    end
    tick();
    n_checks++; if (hit_count !== 32'd3 || miss_count !== 32'd6) begin
      n_fail++; $display("FAIL counts hit %0d miss %0d exp 3 6", hit_count, miss_count);
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    send_word(32'h500, 32'hAAAA_0001);
    send_word(32'h504, 32'hAAAA_0002);
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_full ready %0b valid %0b exp 0 1", in_ready, out_valid);
    end
    reset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || hit_count !== 32'd0 || miss_count !== 32'd0) begin
      n_fail++; $display("FAIL async_reset valid %0b hit %0d miss %0d exp 0 0 0", out_valid, hit_count, miss_count);
    end
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    send_word(32'h600, 32'hBBBB_0003);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_early got %0b exp 0", out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_raw !== 32'hBBBB_0003 || out_hit !== 1'b0) begin
      n_fail++; $display("FAIL post_rst_word valid %0b raw %h hit %0b exp 1 bbbb0003 0", out_valid, out_raw, out_hit);
    end
    tick();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
    dict_we = 1'b0; dict_sel = '0; dict_idx = '0; dict_val = '0; dict_clear = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_hit();
    test_miss();
    test_back_to_back();
    test_priority_clear();
    test_same_edge_write();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
